// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage plus the IF/ID pipeline register.
// Holds the fetch PC and keeps at most one instruction-memory request in
// flight. Fetched words are loaded into IF/ID, or parked in a hold buffer
// while decode is stalled. A taken redirect from decode (takeBranch/branch_PC)
// re-targets fetch and inserts a NOP bubble into IF/ID.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   imem_req, imem_addr   one-cycle request strobe and address (= fetch PC)
//   imem_rvalid/rdata     response strobe and instruction word
//   stall_IFID            hold IF/ID and do not advance
//   takeBranch, branch_PC redirect request and target from decode
//   *_IFID_out            registered IF/ID instruction, PC, PC+4, valid
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall_IFID,
  input  logic        takeBranch,
  input  logic [31:0] branch_PC,
  output logic [31:0] instruction_IFID_out,
  output logic [31:0] PC_IFID_out,
  output logic [31:0] PC_plus4_IFID_out,
  output logic        valid_IFID_out
);

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_hold_buf;
  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic [31:0] r_pc4;
  logic        r_valid;

  logic        w_redirect;
  logic        w_load;
  logic [31:0] w_load_word;
  logic [31:0] w_pc_plus4;

  // A redirect only counts when decode holds a real, non-stalled instruction.
  assign w_redirect = takeBranch & r_valid & ~stall_IFID;
  assign w_pc_plus4 = r_fetch_pc + 32'd4;

  assign imem_req  = (r_state == ST_ISSUE) & ~w_redirect;
  assign imem_addr = r_fetch_pc;

  assign instruction_IFID_out = r_instr;
  assign PC_IFID_out          = r_pc;
  assign PC_plus4_IFID_out    = r_pc4;
  assign valid_IFID_out       = r_valid;

  // Which word (if any) is ready to enter IF/ID this cycle.
  always_comb begin
    w_load      = 1'b0;
    w_load_word = imem_rdata;
    case (r_state)
      ST_WAIT: w_load = imem_rvalid & ~stall_IFID;
      ST_HOLD: begin
        w_load      = ~stall_IFID;
        w_load_word = r_hold_buf;
      end
      default: w_load = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_ISSUE;
      r_fetch_pc <= RESET_PC;
      r_hold_buf <= '0;
      r_instr    <= NOP_INSTR;
      r_pc       <= RESET_PC;
      r_pc4      <= RESET_PC + 32'd4;
      r_valid    <= 1'b0;
    end else if (w_redirect) begin
      // Redirect overrides every state action; an in-flight response that
      // has not yet arrived must still be drained, hence FLUSH.
      r_instr    <= NOP_INSTR;
      r_valid    <= 1'b0;
      r_fetch_pc <= branch_PC;
      r_hold_buf <= '0;
      r_state    <= (r_state == ST_WAIT && !imem_rvalid) ? ST_FLUSH : ST_ISSUE;
    end else begin
      if (w_load) begin
        r_instr    <= w_load_word;
        r_pc       <= r_fetch_pc;
        r_pc4      <= w_pc_plus4;
        r_valid    <= 1'b1;
        r_fetch_pc <= w_pc_plus4;
      end else if (!stall_IFID) begin
        // Advancing with nothing ready: bubble, PC fields kept.
        r_instr <= NOP_INSTR;
        r_valid <= 1'b0;
      end

      case (r_state)
        ST_ISSUE: r_state <= ST_WAIT;
        ST_WAIT: begin
          if (imem_rvalid) begin
            if (stall_IFID) begin
              r_hold_buf <= imem_rdata;
              r_state    <= ST_HOLD;
            end else begin
              r_state <= ST_ISSUE;
            end
          end
        end
        ST_HOLD:  if (!stall_IFID) r_state <= ST_ISSUE;
        ST_FLUSH: if (imem_rvalid) r_state <= ST_ISSUE;
        default:  r_state <= ST_ISSUE;
      endcase
    end
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register, directly upstream of decode. It holds the fetch PC and issues one instruction-memory request at a time. It drives the IF/ID outputs that decode consumes (instruction, PC, PC+4) and applies decode's `takeBranch`/`branch_PC` redirect. It honours a stall from the hazard logic, and flushes by inserting a NOP bubble.

## Interface
- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset.
- `NOP_INSTR`, default `32'h0000_0013`: bubble instruction (`addi x0,x0,0`).

Ports:
- `clk`  in  1  Clock. All state updates on the rising edge.
- `rst_n`  in  1  Reset: asynchronous, active-low.
- `imem_req`  out  1  One-cycle request strobe to instruction memory.
- `imem_addr`  out  32  Request address; equals `fetch_pc`.
- `imem_rvalid`  in  1  Response strobe. Exactly one per request, at least 1 cycle after `imem_req`.
- `imem_rdata`  in  32  Instruction word; valid only while `imem_rvalid` is high.
- `stall_IFID`  in  1  Hold the IF/ID register and do not advance.
- `takeBranch`  in  1  Redirect request from decode (combinational in decode).
- `branch_PC`  in  32  Redirect target.
- `instruction_IFID_out`  out  32  IF/ID instruction.
- `PC_IFID_out`  out  32  IF/ID PC.
- `PC_plus4_IFID_out`  out  32  IF/ID PC+4.
- `valid_IFID_out`  out  1  IF/ID holds a real instruction (0 = bubble).

## Operation
- Internal state: `fetch_pc` (32 bits), `hold_buf` (32 bits), and a 2-bit FSM with states ISSUE, WAIT, HOLD, FLUSH.
- `redirect = takeBranch & valid_IFID_out & ~stall_IFID`. `takeBranch` has no effect when the IF/ID entry is a bubble or is stalled.
- `imem_req = (state==ISSUE) & ~redirect`. `imem_addr = fetch_pc` in every state.
- Advancing the IF/ID register (`~stall_IFID`) with no instruction ready loads a bubble: `NOP_INSTR`, valid 0. PC fields are unchanged.
- Loading an instruction sets instruction = word, PC = `fetch_pc`, PC+4 = `fetch_pc+4`, valid = 1, and sets `fetch_pc <= fetch_pc+4`.
- On `redirect`, these take priority over every state action:
  - IF/ID loads a bubble.
  - `fetch_pc <= branch_PC`.
  - `hold_buf` is discarded.
  - Next state is FLUSH if in WAIT without `imem_rvalid`; otherwise ISSUE.
- FSM transitions:
  - **ISSUE:** request issued, go to WAIT. `imem_rvalid` in this state is ignored (protocol error).
  - **WAIT, `imem_rvalid` and `~stall_IFID`:** load `imem_rdata` into IF/ID, go to ISSUE.
  - **WAIT, `imem_rvalid` and `stall_IFID`:** `hold_buf <= imem_rdata`, go to HOLD.
  - **WAIT, no `imem_rvalid`:** stay in WAIT; IF/ID takes a bubble when not stalled.
  - **HOLD:** when `~stall_IFID`, load `hold_buf` into IF/ID and go to ISSUE; otherwise stay.
  - **FLUSH:** wait for `imem_rvalid`, drop the word, go to ISSUE. IF/ID takes bubbles when not stalled.
- Arithmetic: 32-bit with wrap-around, so `0xFFFF_FFFC + 4 = 0`. Alignment is not checked; `branch_PC` is used verbatim.

## Timing
- Reset (asynchronous, while `rst_n` low):
  - state = ISSUE, `fetch_pc = RESET_PC`.
  - `instruction_IFID_out = NOP_INSTR`, `PC_IFID_out = RESET_PC`, `PC_plus4_IFID_out = RESET_PC+4`, `valid_IFID_out = 0`.
  - `hold_buf = 0`.
  - `imem_req` is 1 once `rst_n` is released (ISSUE, no redirect because valid is 0).
- Reset mid-request: any outstanding response is ignored. The memory is reset on the same `rst_n`.
- All IF/ID outputs are registered. `imem_req` is combinational from state and `redirect`.
- Latency and throughput with a 1-cycle memory:
  - Request in cycle N, response in N+1, IF/ID valid in N+2, next request in N+2.
  - Throughput is 1 instruction per 2 cycles.
- Redirect observed in cycle N: bubble in IF/ID at N+1.
  - From ISSUE or WAIT-with-`rvalid`, request to `branch_PC` issues at N+1.
  - From WAIT without `rvalid`, request issues the cycle after the stale response arrives.
- There is never more than one outstanding request.

## Test plan
- **Reset and sequential fetch:** memory latency 1, word = address ^ `0xA5A5_0000`, no stalls. Required:
  - `imem_addr` sequence 0, 4, 8.
  - IF/ID shows (`0xA5A5_0000`, PC 0, PC+4 4), then (`0xA5A5_0004`, 4, 8), each valid for exactly one cycle with bubbles (`0x13`, valid 0) between.
- **Stall capture:** `stall_IFID` high over the response to address 8, held 3 cycles. Required:
  - IF/ID is unchanged during the stall.
  - No new `imem_req`.
  - After release, IF/ID = (`0xA5A5_0008`, 8, 12) in the next cycle.
- **Redirect with request outstanding:** memory latency 3; `takeBranch` with `branch_PC = 0x100` while a request to 0x10 is pending. Required:
  - Bubble loaded.
  - The 0x10 response is discarded.
  - Next request is to 0x100; first valid IF/ID PC is 0x100.
- **Redirect coincident with response:** `takeBranch` (target 0x200) in the same cycle as `imem_rvalid`. Required: the word is dropped and `imem_req` to 0x200 is issued the next cycle.
- **Ignored redirects:** `takeBranch` while `valid_IFID_out = 0`, or while `stall_IFID = 1`. Required: no change to `fetch_pc` and no bubble forced.
- **Wrap-around and async reset:**
  - `branch_PC = 0xFFFF_FFFC`. Required: next fetch address is 0 and IF/ID PC+4 = 0.
  - Assert `rst_n` low mid-WAIT. Required: outputs take their reset values immediately, without a clock edge.
